mac_array_ctrl: RTL and testbench
=================================

# mac_array_ctrl

Sequencing controller for the MAC array. Accepts one convolution-tile command at a time and latches the kernel size, operation and active-MAC count. It then issues the single weight-load strobe and streams ifmap columns into the array under a valid/ready handshake. It emits a psum strobe for every complete kernel window and signals completion. It sits between the tile scheduler (command side) and the MAC array, preload buffers and psum capture logic.

## Interface
- MAC_NUM, 256, MAC instances driven; mac_enable width.
- PIPE_LAT, 2, cycles from an accepted column to its psum on psum_out; legal range 1..8.
- COL_W, 16, width of the column-count field.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  tile command present.
- cmd_ready  out  1  controller idle; the command is accepted on cmd_valid && cmd_ready.
- cmd_kernel_size  in  5  kernel edge; legal 1..5.
- cmd_operation  in  2  passed to the array unchanged.
- cmd_mac_count  in  $clog2(MAC_NUM)+1  number of MACs to enable; legal 1..MAC_NUM.
- cmd_num_cols  in  COL_W  ifmap columns in the tile; legal values are ≥ cmd_kernel_size.
- w_ready  in  1  weights are valid on the preload bus.
- if_valid  in  1  ifmap column is valid on the preload bus.
- if_ready  out  1  controller takes the column.
- mac_enable  out  MAC_NUM  per-MAC enable.
- mac_operation  out  2  latched operation.
- mac_kernel_size  out  5  latched kernel size.
- mac_load_weight  out  1  one-cycle weight-load strobe.
- mac_load_ifmaps  out  1  array in ifmap-load mode.
- mac_ifmaps_input_valid  out  1  column-shift strobe.
- psum_valid  out  1  one-cycle strobe; psum_out is valid this cycle. There is no backpressure.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse when the tile completes.
- err  out  1  one-cycle pulse when a command is rejected.

## Operation
- States:
  - IDLE: cmd_ready=1. On acceptance, validate the command.
    - Illegal kernel_size (0 or >5), mac_count (0 or >MAC_NUM) or num_cols (< kernel_size): pulse err next cycle and stay IDLE.
    - Otherwise latch all fields and go to LOAD_W.
  - LOAD_W: mac_load_weight = w_ready (combinational). When w_ready=1, go to STREAM.
  - STREAM:
    - mac_load_ifmaps=1.
    - if_ready=1 while col_cnt < num_cols.
    - mac_ifmaps_input_valid = if_valid && if_ready; each such cycle increments col_cnt.
    - An accepted column whose post-increment col_cnt ≥ kernel_size pushes a 1 into the PIPE_LAT-deep tag shift register; otherwise it pushes 0.
    - When the last column is accepted, go to DRAIN.
  - DRAIN: wait until the tag register is all-zero, then go to IDLE and pulse done.
- The tag register shifts every cycle in all states. psum_valid is its output stage.
- mac_enable is all-zero in IDLE. From LOAD_W through DRAIN it is a thermometer code with bits [mac_count-1:0] set.
- mac_operation and mac_kernel_size hold their last latched values in IDLE.
- Outputs per tile:
  - Exactly num_cols − kernel_size + 1 psum_valid strobes.
  - Exactly one mac_load_weight cycle.
  - Exactly num_cols mac_ifmaps_input_valid cycles.
- A cmd_valid presented while busy is ignored and not latched.

## Timing
- Reset values:
  - State IDLE, all counters 0, tags 0.
  - All outputs 0, except cmd_ready=1.
  - mac_operation=0 and mac_kernel_size=0.
- Command accepted at cycle T: LOAD_W at T+1. With w_ready already high, mac_load_weight is asserted at T+1 and STREAM starts at T+2.
- Column accepted at cycle C that completes a window: psum_valid at C+PIPE_LAT.
- Last column accepted at cycle L: done at L+PIPE_LAT+1. IDLE and cmd_ready=1 in the same cycle as done.
- Rejected command at T: err at T+1. cmd_ready stays 1.
- if_valid gaps stall only the column count. Tags keep shifting, so psum strobes for already-accepted windows are never delayed.
- Reset asserted mid-tile clears everything immediately. No done or psum_valid is emitted after reset.

## Structure
- Shared package `mac_ctrl_pkg`:
  - state enum (IDLE, LOAD_W, STREAM, DRAIN);
  - constant KERNEL_MAX=5;
  - widths for the operation and kernel fields.
- Sub-module `thermo_mask`: combinational conversion of mac_count to the MAC_NUM-bit thermometer mask. It is registered in the controller at command acceptance.
- Counters, tag shift register and FSM live in mac_array_ctrl. Total is roughly 200 lines.

## Test plan
- kernel 3, mac_count 256, num_cols 8, PIPE_LAT 2, if_valid and w_ready always high -> 1 load_weight strobe, 8 input_valid strobes, 6 psum_valid strobes starting 2 cycles after the 3rd column, done 3 cycles after the 8th column.
- Command with kernel_size 6, then one with num_cols 2 and kernel 3, then one with mac_count 0 -> err pulse for each, no state change, mac_enable stays 0.
- w_ready held low 10 cycles after acceptance -> mac_load_weight=0 throughout the wait; if_ready=0; the strobe lands on the first w_ready cycle.
- mac_count 5 -> mac_enable=0x1F during the tile and 0 after done.
- if_valid toggling 1,0,0,1,… for kernel 1, num_cols 4 -> 4 psum strobes, each exactly PIPE_LAT after its column; cmd_valid held high while busy is not accepted until done.
- rst asserted during STREAM after 5 columns -> all outputs at reset values in the same cycle, no later psum_valid or done, and the next command runs normally.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mac_ctrl_pkg : shared types and constants for the MAC array controller
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mac_ctrl_pkg;

  localparam int KERNEL_W = 5;
  localparam int OP_W     = 2;

  localparam logic [KERNEL_W-1:0] KERNEL_MAX = KERNEL_W'(5);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  function automatic logic kernel_legal(input logic [KERNEL_W-1:0] k);
    return (k != '0) && (k <= KERNEL_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_array_ctrl_if.sv
// ----------------------------------------------------------------------------
// mac_array_ctrl_if : command, preload and MAC-array signals of the controller
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mac_array_ctrl_if
  import mac_ctrl_pkg::*;
#(
  parameter int MAC_NUM = 256,
  parameter int COL_W   = 16
);

  localparam int CNT_W = $clog2(MAC_NUM) + 1;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [KERNEL_W-1:0] cmd_kernel_size;
  logic [OP_W-1:0]     cmd_operation;
  logic [CNT_W-1:0]    cmd_mac_count;
  logic [COL_W-1:0]    cmd_num_cols;
  logic                w_ready;
  logic                if_valid;
  logic                if_ready;
  logic [MAC_NUM-1:0]  mac_enable;
  logic [OP_W-1:0]     mac_operation;
  logic [KERNEL_W-1:0] mac_kernel_size;
  logic                mac_load_weight;
  logic                mac_load_ifmaps;
  logic                mac_ifmaps_input_valid;
  logic                psum_valid;
  logic                busy;
  logic                done;
  logic                err;

  // Controller side
  modport master (
    input  cmd_valid, cmd_kernel_size, cmd_operation, cmd_mac_count, cmd_num_cols,
    input  w_ready, if_valid,
    output cmd_ready, if_ready, mac_enable, mac_operation, mac_kernel_size,
    output mac_load_weight, mac_load_ifmaps, mac_ifmaps_input_valid,
    output psum_valid, busy, done, err
  );

  // Scheduler / array side
  modport slave (
    output cmd_valid, cmd_kernel_size, cmd_operation, cmd_mac_count, cmd_num_cols,
    output w_ready, if_valid,
    input  cmd_ready, if_ready, mac_enable, mac_operation, mac_kernel_size,
    input  mac_load_weight, mac_load_ifmaps, mac_ifmaps_input_valid,
    input  psum_valid, busy, done, err
  );

endinterface

`default_nettype wire

// File: rtl/thermo_mask.sv
// ----------------------------------------------------------------------------
// thermo_mask : mac_count to MAC_NUM-bit thermometer enable mask
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module thermo_mask #(
  parameter int MAC_NUM = 256,
  parameter int CNT_W   = $clog2(MAC_NUM) + 1
) (
  input  logic [CNT_W-1:0]   mac_count,
  output logic [MAC_NUM-1:0] mask
);

  for (genvar i = 0; i < MAC_NUM; i++) begin : g_bit
    assign mask[i] = (mac_count > CNT_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/mac_array_ctrl.sv
// ----------------------------------------------------------------------------
// mac_array_ctrl : tile sequencer driving weight load, ifmap stream and psums
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int MAC_NUM  = 256,
  parameter int PIPE_LAT = 2,
  parameter int COL_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  mac_array_ctrl_if.master ctrl_bus
);

  localparam int               CNT_W     = $clog2(MAC_NUM) + 1;
  localparam logic [CNT_W-1:0] C_MAC_MAX = CNT_W'(MAC_NUM);

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_cnt_q, col_cnt_d;
  logic [COL_W-1:0]    num_cols_q, num_cols_d;
  logic [KERNEL_W-1:0] kernel_q, kernel_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [MAC_NUM-1:0]  mask_q, mask_d;
  logic [PIPE_LAT-1:0] tag_q, tag_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic [MAC_NUM-1:0]  mask_w;
  logic                cmd_fire_w;
  logic                cmd_legal_w;
  logic                if_ready_w;
  logic                col_fire_w;
  logic                col_push_w;
  logic [COL_W-1:0]    col_next_w;

  thermo_mask #(
    .MAC_NUM (MAC_NUM),
    .CNT_W   (CNT_W)
  ) u_thermo_mask (
    .mac_count (ctrl_bus.cmd_mac_count),
    .mask      (mask_w)
  );

  assign cmd_fire_w  = ctrl_bus.cmd_valid && (state_q == IDLE);
  assign cmd_legal_w = kernel_legal(ctrl_bus.cmd_kernel_size)
                    && (ctrl_bus.cmd_mac_count != '0)
                    && (ctrl_bus.cmd_mac_count <= C_MAC_MAX)
                    && (ctrl_bus.cmd_num_cols >= COL_W'(ctrl_bus.cmd_kernel_size));

  assign if_ready_w  = (state_q == STREAM) && (col_cnt_q < num_cols_q);
  assign col_fire_w  = ctrl_bus.if_valid && if_ready_w;
  assign col_next_w  = col_cnt_q + COL_W'(1);
  // A column closes a window once at least kernel_size columns have arrived
  assign col_push_w  = col_fire_w && (col_next_w >= COL_W'(kernel_q));

  always_comb begin
    state_d    = state_q;
    col_cnt_d  = col_cnt_q;
    num_cols_d = num_cols_q;
    kernel_d   = kernel_q;
    op_d       = op_q;
    mask_d     = mask_q;
    err_d      = 1'b0;
    done_d     = 1'b0;
    tag_d      = tag_q << 1;
    tag_d[0]   = col_push_w;

    case (state_q)
      IDLE: begin
        if (cmd_fire_w) begin
          if (cmd_legal_w) begin
            kernel_d   = ctrl_bus.cmd_kernel_size;
            op_d       = ctrl_bus.cmd_operation;
            num_cols_d = ctrl_bus.cmd_num_cols;
            mask_d     = mask_w;
            col_cnt_d  = '0;
            state_d    = LOAD_W;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_W: begin
        if (ctrl_bus.w_ready) state_d = STREAM;
      end
      STREAM: begin
        if (col_fire_w) begin
          col_cnt_d = col_next_w;
          if (col_next_w == num_cols_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as the final tag exits so done coincides with the return to IDLE
        if (tag_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      col_cnt_q  <= '0;
      num_cols_q <= '0;
      kernel_q   <= '0;
      op_q       <= '0;
      mask_q     <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_cnt_q  <= col_cnt_d;
      num_cols_q <= num_cols_d;
      kernel_q   <= kernel_d;
      op_q       <= op_d;
      mask_q     <= mask_d;
      tag_q      <= tag_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign ctrl_bus.cmd_ready              = (state_q == IDLE);
  assign ctrl_bus.busy                   = (state_q != IDLE);
  assign ctrl_bus.if_ready               = if_ready_w;
  assign ctrl_bus.mac_enable             = (state_q == IDLE) ? '0 : mask_q;
  assign ctrl_bus.mac_operation          = op_q;
  assign ctrl_bus.mac_kernel_size        = kernel_q;
  assign ctrl_bus.mac_load_weight        = (state_q == LOAD_W) && ctrl_bus.w_ready;
  assign ctrl_bus.mac_load_ifmaps        = (state_q == STREAM);
  assign ctrl_bus.mac_ifmaps_input_valid = col_fire_w;
  assign ctrl_bus.psum_valid             = tag_q[PIPE_LAT-1];
  assign ctrl_bus.done                   = done_q;
  assign ctrl_bus.err                    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_array_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mac_array_ctrl : self-checking bench for mac_array_ctrl
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mac_array_ctrl;
  import mac_ctrl_pkg::*;

  localparam int MAC_NUM  = 256;
  localparam int PIPE_LAT = 2;
  localparam int COL_W    = 16;
  localparam int CNT_W    = $clog2(MAC_NUM) + 1;

  logic clk = 1'b0;
  logic rst;

  mac_array_ctrl_if #(.MAC_NUM(MAC_NUM), .COL_W(COL_W)) ctrl_bus ();

  mac_array_ctrl #(
    .MAC_NUM  (MAC_NUM),
    .PIPE_LAT (PIPE_LAT),
    .COL_W    (COL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ctrl_bus (ctrl_bus.master)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [MAC_NUM-1:0] thermo(input int c);
    logic [MAC_NUM-1:0] m;
    m = '0;
    for (int i = 0; i < c; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic drive_cmd(input int k, input int op, input int mc, input int nc);
    ctrl_bus.cmd_valid       = 1'b1;
    ctrl_bus.cmd_kernel_size = KERNEL_W'(k);
    ctrl_bus.cmd_operation   = OP_W'(op);
    ctrl_bus.cmd_mac_count   = CNT_W'(mc);
    ctrl_bus.cmd_num_cols    = COL_W'(nc);
  endtask

  // gap: 0 = if_valid always high, 1 = random, 2 = repeating 1,0,0
  // hold: keep an illegal command on the bus for the whole tile
  task automatic run_tile(input int k, input int op, input int mc, input int nc,
                          input int wdelay, input int gap, input bit hold);
    int exp_acc[$];
    int got_acc[$];
    int got_psum[$];
    int exp_psum[$];
    int lw_n = -1, lw_cnt = 0, done_n = -1, err_seen = 0;
    int en_bad = 0, rdy_bad = 0, ifr_bad = 0, acc_bad = 0, psum_bad = 0, exp_done;
    bit ivd;
    logic [MAC_NUM-1:0] mask;
    mask = thermo(mc);

    @(posedge clk); #1;
    drive_cmd(k, op, mc, nc);
    ctrl_bus.w_ready  = (wdelay == 0);
    ctrl_bus.if_valid = 1'b0;
    @(negedge clk);
    check("cmd_ready_before_accept", ctrl_bus.cmd_ready, 1);

    for (int n = 1; n <= 400 && done_n < 0; n++) begin
      @(posedge clk); #1;
      ctrl_bus.cmd_valid = hold;
      if (hold) begin
        ctrl_bus.cmd_kernel_size = 5'd6;
        ctrl_bus.cmd_operation   = 2'd3;
      end
      ctrl_bus.w_ready = (n > wdelay);
      case (gap)
        0:       ivd = 1'b1;
        1:       ivd = 1'($urandom_range(0, 1));
        default: ivd = (((n - wdelay - 2) % 3) == 0);
      endcase
      ctrl_bus.if_valid = ivd;
      // Weights land at wdelay+1, streaming begins the cycle after
      if (ivd && n >= wdelay + 2 && exp_acc.size() < nc) exp_acc.push_back(n);
      @(negedge clk);
      if (ctrl_bus.mac_load_weight) begin
        lw_cnt++;
        if (lw_n < 0) lw_n = n;
      end
      if (ctrl_bus.mac_ifmaps_input_valid) got_acc.push_back(n);
      if (ctrl_bus.psum_valid) got_psum.push_back(n);
      if (ctrl_bus.err) err_seen++;
      if (n <= wdelay + 1 && ctrl_bus.if_ready) ifr_bad++;
      if (ctrl_bus.done) done_n = n;
      else begin
        if (ctrl_bus.mac_enable !== mask) en_bad++;
        if (ctrl_bus.cmd_ready || !ctrl_bus.busy) rdy_bad++;
      end
    end

    for (int i = k - 1; i < exp_acc.size(); i++) exp_psum.push_back(exp_acc[i] + PIPE_LAT);
    exp_done = (exp_acc.size() == nc) ? exp_acc[nc-1] + PIPE_LAT + 1 : -2;

    for (int i = 0; i < nc; i++)
      if (i >= got_acc.size() || i >= exp_acc.size() || got_acc[i] != exp_acc[i]) acc_bad++;
    for (int i = 0; i < exp_psum.size(); i++)
      if (i >= got_psum.size() || got_psum[i] != exp_psum[i]) psum_bad++;

    check("load_weight_count",  lw_cnt, 1);
    check("load_weight_cycle",  lw_n, wdelay + 1);
    check("if_ready_in_load_w", ifr_bad, 0);
    check("input_valid_count",  got_acc.size(), nc);
    check("input_valid_cycles", acc_bad, 0);
    check("psum_count",         got_psum.size(), nc - k + 1);
    check("psum_cycles",        psum_bad, 0);
    check("done_cycle",         done_n, exp_done);
    check("mac_enable_in_tile", en_bad, 0);
    check("busy_in_tile",       rdy_bad, 0);
    check("no_err_in_tile",     err_seen, 0);
    check("idle_at_done",       {ctrl_bus.cmd_ready, ctrl_bus.busy}, 2'b10);
    check("mac_enable_at_done", ctrl_bus.mac_enable, 0);
    check("kernel_latched",     ctrl_bus.mac_kernel_size, k);
    check("op_latched",         ctrl_bus.mac_operation, op);

    @(posedge clk); #1;
    ctrl_bus.cmd_valid = 1'b0;
    ctrl_bus.if_valid  = 1'b0;
    @(negedge clk);
    check("held_cmd_after_done", ctrl_bus.err, hold);
  endtask

  typedef struct {
    int k;
    int op;
    int mc;
    int nc;
    bit exp_err;
    bit exp_busy;
  } cmd_vec_t;

  cmd_vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt, late;

    rst = 1'b1;
    ctrl_bus.cmd_valid = 1'b0;
    ctrl_bus.cmd_kernel_size = '0;
    ctrl_bus.cmd_operation = '0;
    ctrl_bus.cmd_mac_count = '0;
    ctrl_bus.cmd_num_cols = '0;
    ctrl_bus.w_ready = 1'b0;
    ctrl_bus.if_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl_outputs",
          {ctrl_bus.cmd_ready, ctrl_bus.if_ready, ctrl_bus.busy, ctrl_bus.done, ctrl_bus.err,
           ctrl_bus.psum_valid, ctrl_bus.mac_load_weight, ctrl_bus.mac_load_ifmaps,
           ctrl_bus.mac_ifmaps_input_valid}, 9'b1_0000_0000);
    check("reset_mac_enable", ctrl_bus.mac_enable, 0);
    check("reset_latched_fields", {ctrl_bus.mac_operation, ctrl_bus.mac_kernel_size}, 0);
    rst = 1'b0;

    // Rejected commands: bad kernel, too few columns, zero / oversize MAC count
    vecs[0] = '{k: 6, op: 3, mc: 8,   nc: 8,  exp_err: 1'b1, exp_busy: 1'b0};
    vecs[1] = '{k: 3, op: 1, mc: 8,   nc: 2,  exp_err: 1'b1, exp_busy: 1'b0};
    vecs[2] = '{k: 3, op: 2, mc: 0,   nc: 8,  exp_err: 1'b1, exp_busy: 1'b0};
    vecs[3] = '{k: 0, op: 1, mc: 4,   nc: 4,  exp_err: 1'b1, exp_busy: 1'b0};
    vecs[4] = '{k: 2, op: 3, mc: 257, nc: 4,  exp_err: 1'b1, exp_busy: 1'b0};
    vecs[5] = '{k: 5, op: 2, mc: 16,  nc: 4,  exp_err: 1'b1, exp_busy: 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive_cmd(vecs[i].k, vecs[i].op, vecs[i].mc, vecs[i].nc);
      @(posedge clk); #1;
      ctrl_bus.cmd_valid = 1'b0;
      @(negedge clk);
      check($sformatf("rej%0d_err", i), ctrl_bus.err, vecs[i].exp_err);
      check($sformatf("rej%0d_state", i), {ctrl_bus.busy, ctrl_bus.cmd_ready},
            {vecs[i].exp_busy, 1'b1});
      check($sformatf("rej%0d_enable", i), ctrl_bus.mac_enable, 0);
      check($sformatf("rej%0d_fields", i),
            {ctrl_bus.mac_operation, ctrl_bus.mac_kernel_size}, 0);
      @(negedge clk);
      check($sformatf("rej%0d_err_pulse", i), ctrl_bus.err, 0);
    end

    run_tile(3, 2, 256, 8, 0, 0, 1'b0);
    run_tile(2, 1, 5, 5, 10, 0, 1'b0);
    run_tile(1, 3, 17, 4, 0, 2, 1'b1);
    run_tile(5, 0, 1, 5, 1, 1, 1'b0);

    // Reset in the middle of streaming with windows still in flight
    @(posedge clk); #1;
    drive_cmd(3, 2, 7, 8);
    ctrl_bus.w_ready  = 1'b1;
    ctrl_bus.if_valid = 1'b1;
    @(posedge clk); #1;
    ctrl_bus.cmd_valid = 1'b0;
    cnt = 0;
    for (int n = 0; n < 50 && cnt < 5; n++) begin
      @(negedge clk);
      if (ctrl_bus.mac_ifmaps_input_valid) cnt++;
    end
    check("cols_before_reset", cnt, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midtile_reset_ctrl",
          {ctrl_bus.cmd_ready, ctrl_bus.if_ready, ctrl_bus.busy, ctrl_bus.done, ctrl_bus.err,
           ctrl_bus.psum_valid, ctrl_bus.mac_load_weight, ctrl_bus.mac_load_ifmaps,
           ctrl_bus.mac_ifmaps_input_valid}, 9'b1_0000_0000);
    check("midtile_reset_enable", ctrl_bus.mac_enable, 0);
    check("midtile_reset_fields", {ctrl_bus.mac_operation, ctrl_bus.mac_kernel_size}, 0);
    ctrl_bus.if_valid = 1'b0;
    ctrl_bus.w_ready  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    late = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (ctrl_bus.psum_valid || ctrl_bus.done || ctrl_bus.busy) late++;
    end
    check("quiet_after_reset", late, 0);
    run_tile(3, 1, 200, 6, 0, 0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      int k, nc;
      k  = int'($urandom_range(1, 5));
      nc = k + int'($urandom_range(0, 10));
      run_tile(k, int'($urandom_range(0, 3)), int'($urandom_range(1, MAC_NUM)), nc,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
